// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module   : alu_arb_pkg
// Brief    : Shared types and widths for the ALU arbiter/sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  localparam int OPCODE_W = 4;
  localparam int FUNCT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker, searching upward from the
//            requester after the last one served and wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last_grant,
  output logic [N_REQ-1:0]         o_grant_oh,
  output logic [$clog2(N_REQ)-1:0] o_grant_idx,
  output logic                     o_any
);

  localparam int IDX_W = $clog2(N_REQ);

  always_comb begin
    int w_idx;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = 0;
    // Offset N_REQ lands back on last_grant itself, so it has lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(i_last_grant) + k) % N_REQ;
      if (!o_any && i_req[w_idx]) begin
        o_any             = 1'b1;
        o_grant_oh[w_idx] = 1'b1;
        o_grant_idx       = IDX_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one variable-latency ALU between N_REQ requesters, one
//            operation at a time, with a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*OPCODE_W-1:0]  req_opcode,
  input  logic [N_REQ*FUNCT_W-1:0]   req_funct,
  input  logic [N_REQ*DATA_W-1:0]    req_a,
  input  logic [N_REQ*DATA_W-1:0]    req_b,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [DATA_W-1:0]          rsp_o,
  output logic                       rsp_overflow,
  output logic                       rsp_timeout,
  output logic                       alu_valid_i,
  output logic [OPCODE_W-1:0]        alu_opcode,
  output logic [FUNCT_W-1:0]         alu_funct,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  input  logic [DATA_W-1:0]          alu_o,
  input  logic                       alu_valid_o,
  input  logic                       alu_overflow,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  arb_state_e          r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_last_grant;
  logic [OPCODE_W-1:0] r_opcode;
  logic [FUNCT_W-1:0]  r_funct;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rsp_o;
  logic                r_rsp_ov;
  logic                r_rsp_to;

  logic [N_REQ-1:0]    w_pick_oh;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic                w_handshake;
  logic [OPCODE_W-1:0] w_sel_opcode;
  logic [FUNCT_W-1:0]  w_sel_funct;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant_oh   (w_pick_oh),
    .o_grant_idx  (w_pick_idx),
    .o_any        (w_pick_any)
  );

  assign w_sel_opcode = req_opcode[int'(w_pick_idx)*OPCODE_W +: OPCODE_W];
  assign w_sel_funct  = req_funct[int'(w_pick_idx)*FUNCT_W +: FUNCT_W];
  assign w_sel_a      = req_a[int'(w_pick_idx)*DATA_W +: DATA_W];
  assign w_sel_b      = req_b[int'(w_pick_idx)*DATA_W +: DATA_W];

  // Grant is suppressed while reset is held so no handshake is ever seen then.
  assign w_handshake = (r_state == ST_IDLE) && w_pick_any && !rst;
  assign req_ready   = w_handshake ? w_pick_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_opcode     <= '0;
      r_funct      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_rsp_o      <= '0;
      r_rsp_ov     <= 1'b0;
      r_rsp_to     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_grant  <= w_pick_idx;
            r_opcode <= w_sel_opcode;
            r_funct  <= w_sel_funct;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_valid_o) begin
            r_rsp_o  <= alu_o;
            r_rsp_ov <= alu_overflow;
            r_rsp_to <= 1'b0;
            r_state  <= ST_RESP;
          end else if (r_cnt == c_cnt_last) begin
            r_rsp_o  <= '0;
            r_rsp_ov <= 1'b0;
            r_rsp_to <= 1'b1;
            r_state  <= ST_RESP;
          end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready[r_grant]) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid    = (r_state == ST_RESP) ? (N_REQ'(1) << r_grant) : '0;
  assign rsp_o        = r_rsp_o;
  assign rsp_overflow = r_rsp_ov;
  assign rsp_timeout  = r_rsp_to;
  assign alu_valid_i  = (r_state == ST_ISSUE);
  assign alu_opcode   = r_opcode;
  assign alu_funct    = r_funct;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one `alu` instance between `N_REQ` independent requesters. It accepts one operation at a time over a per-requester valid/ready request channel and issues it to the ALU as a single-cycle `valid_i` pulse. It then waits for the ALU's variable-latency `valid_o`, with a timeout, and returns the result on a per-requester valid/ready response channel. It sits between the instruction-issue logic and the `alu` datapath.

## Interface
- `DATA_W`, 32: operand/result width; must match the `alu` instance.
- `N_REQ`, 4: number of requesters, at least 2.
- `TIMEOUT_CYC`, 64: maximum number of WAIT cycles before a response is forced.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_ready`  out  N_REQ: per-requester accept; at most one bit high.
- `req_opcode`  in  N_REQ*4: opcode per requester, packed with requester i at bits [4i+3:4i].
- `req_funct`  in  N_REQ*3: funct per requester, packed.
- `req_a`, `req_b`  in  N_REQ*DATA_W: operands per requester, packed.
- `rsp_valid`  out  N_REQ: one-hot response valid to the granted requester.
- `rsp_ready`  in  N_REQ: per-requester response accept.
- `rsp_o`  out  DATA_W: result, shared by all requesters.
- `rsp_overflow`  out  1: ALU overflow flag of the returned result.
- `rsp_timeout`  out  1: set when the result was forced by timeout.
- `alu_valid_i`  out  1: issue pulse to the ALU.
- `alu_opcode`  out  4: opcode to the ALU.
- `alu_funct`  out  3: funct to the ALU.
- `alu_a`, `alu_b`  out  DATA_W: operands to the ALU.
- `alu_o`  in  DATA_W: ALU result.
- `alu_valid_o`  in  1: ALU result valid.
- `alu_overflow`  in  1: ALU overflow flag.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Round-robin pick among `req_valid`, searching from `last_grant+1` and wrapping modulo `N_REQ`.
  - `req_ready[pick]` = 1, combinational.
  - On handshake, latch opcode, funct, a, b and `grant`, then go to ISSUE.
  - If no `req_valid` is high, stay in IDLE and drive `req_ready` = 0.
- ISSUE: `alu_valid_i` = 1 for exactly one cycle; clear the WAIT counter; go to WAIT.
- WAIT:
  - `alu_*` operand outputs stay driven from the latched registers; `alu_valid_i` = 0.
  - On `alu_valid_o`, capture `alu_o` and `alu_overflow`, clear the timeout flag, and go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYC`-1 with no `alu_valid_o`, set `rsp_o` = 0, `rsp_overflow` = 0, `rsp_timeout` = 1, and go to RESP.
- RESP:
  - `rsp_valid[grant]` = 1; `rsp_o`, `rsp_overflow` and `rsp_timeout` are held stable.
  - On `rsp_ready[grant]`, set `last_grant` = `grant` and go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `alu_valid_o` is ignored in IDLE, ISSUE and RESP. A late `alu_valid_o` after a timeout is discarded.
- Only one operation is outstanding at any time, and `req_ready` is 0 in every state except IDLE.
- Request inputs may change freely while their requester is not granted. After a handshake, changes to the granted requester's inputs have no effect.
- Fairness: a continuously requesting requester waits at most `N_REQ`-1 other operations.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = `N_REQ`-1, so requester 0 has first priority.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_o` = 0, `rsp_overflow` = 0, `rsp_timeout` = 0.
  - `alu_valid_i` = 0, `alu_opcode` = 0, `alu_funct` = 0, `alu_a` = 0, `alu_b` = 0, `busy` = 0.
- Reset asserted in any state aborts the operation and returns to IDLE on the next edge; no response is produced for it.
- Latency:
  - Handshake in cycle 0, `alu_valid_i` in cycle 1.
  - If the ALU asserts `valid_o` in cycle 1+L (L ≥ 1), `rsp_valid` is high from cycle 2+L.
  - The earliest next handshake is the cycle after the `rsp_ready` handshake.
- Timeout: `rsp_valid` is high TIMEOUT_CYC+2 cycles after the request handshake.
- Arithmetic: the WAIT counter is $clog2(TIMEOUT_CYC+1) bits wide and saturates; `grant` and `last_grant` are $clog2(N_REQ) bits wide.

## Structure
- Package `alu_arb_pkg`:
  - state enum `arb_state_e` (IDLE, ISSUE, WAIT, RESP);
  - `OPCODE_W` = 4, `FUNCT_W` = 3.
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs: request vector, `last_grant`. Outputs: one-hot grant and grant index.
- The FSM, operand registers, result registers and timeout counter live in `alu_arbiter`.

## Test plan
- Single requester: requester 1 sends opcode 0001, funct 000, a = 0xA5A5A5A5, b = 0x5A5A5A5A, and the ALU model returns 0x00000000 after L = 1. Expect `alu_valid_i` high for exactly 1 cycle, `rsp_valid` = 4'b0010 in cycle 3, `rsp_o` = 0x00000000, `rsp_overflow` = 0.
- All four requesters hold `req_valid` from reset. Expect grants in the order 0, 1, 2, 3, 0, and never the same requester twice while others are pending.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP. Expect `rsp_valid`, `rsp_o` and `rsp_timeout` stable, `req_ready` = 0, and no `alu_valid_i`.
- Timeout with `TIMEOUT_CYC` = 8 and the ALU never asserting `valid_o`. Expect `rsp_timeout` = 1 and `rsp_o` = 0 at handshake+10. A stray `alu_valid_o` afterwards does not change the response.
- Reset asserted in WAIT: all outputs are at reset values on the next edge. A subsequent lone request from requester 2 is granted and completes normally.
- Real `alu` instance: requester 3 sends opcode 1001 (carry-less multiply), a = 0x0000000F, b = 0x00000007. Expect `rsp_o` = 0x0000002D and `rsp_overflow` = 0 regardless of the multi-cycle latency.
